// File: rtl/fp_pkg.sv
// Shared widths and mantissa types for the floating-point adder datapath.
package fp_pkg;
    localparam int MANT_W = 23;
    localparam int EXP_W  = 8;

    typedef logic [MANT_W-1:0] mant_t;
    typedef logic [MANT_W:0]   mant_sum_t;
endpackage

// File: rtl/fpbus.sv
// Connection bundle between alignment, mantissa ALU and normalization stages.
interface fpbus;
    import fp_pkg::*;

    logic      clk;
    logic      rst_n;
    logic      signA;
    logic      signB;
    mant_t     alignedMantissaA;
    mant_t     alignedMantissaB;
    mant_t     alignedResult;
    logic      alignedSign;
    logic      carryOut;
    mant_t     aluResultQ;
    logic      aluSignQ;
    logic      aluCarryQ;

    modport alu (
        input  clk,
        input  rst_n,
        input  signA,
        input  signB,
        input  alignedMantissaA,
        input  alignedMantissaB,
        output alignedResult,
        output alignedSign,
        output carryOut,
        output aluResultQ,
        output aluSignQ,
        output aluCarryQ
    );
endinterface

// File: rtl/alu_addsub.sv
// Combinational sign-magnitude add/subtract of two aligned mantissas.
module alu_addsub #(
    parameter int MANT_W = fp_pkg::MANT_W
) (
    input  logic              sign_a,
    input  logic              sign_b,
    input  logic [MANT_W-1:0] mant_a,
    input  logic [MANT_W-1:0] mant_b,
    output logic [MANT_W-1:0] result,
    output logic              sign,
    output logic              carry
);
    logic            same_sign;
    logic            a_gt_b;
    logic            b_gt_a;
    logic [MANT_W:0] sum_full;
    logic [MANT_W-1:0] diff;

    assign same_sign = ~(sign_a ^ sign_b);
    assign a_gt_b    = mant_a > mant_b;
    assign b_gt_a    = mant_b > mant_a;
    assign sum_full  = {1'b0, mant_a} + {1'b0, mant_b};

    // Always subtract the smaller magnitude so no borrow can occur; equal gives 0.
    assign diff = a_gt_b ? (mant_a - mant_b) : (mant_b - mant_a);

    // Ternaries rather than if/else so unknown inputs stay visible on the outputs.
    assign result = same_sign ? sum_full[MANT_W-1:0] : diff;
    assign sign   = same_sign ? sign_a :
                    a_gt_b    ? sign_a :
                    b_gt_a    ? sign_b : 1'b0;
    assign carry  = same_sign & sum_full[MANT_W];
endmodule

// File: rtl/alu.sv
// Mantissa ALU: combinational add/sub plus a one-cycle output register bank.
module alu #(
    parameter int MANT_W = fp_pkg::MANT_W
) (
    fpbus.alu bus
);
    logic [MANT_W-1:0] result_next;
    logic              sign_next;
    logic              carry_next;
    logic [MANT_W-1:0] result_reg;
    logic              sign_reg;
    logic              carry_reg;

    alu_addsub #(.MANT_W(MANT_W)) u_addsub (
        .sign_a (bus.signA),
        .sign_b (bus.signB),
        .mant_a (bus.alignedMantissaA),
        .mant_b (bus.alignedMantissaB),
        .result (result_next),
        .sign   (sign_next),
        .carry  (carry_next)
    );

    always_ff @(posedge bus.clk or negedge bus.rst_n) begin
        if (!bus.rst_n) begin
            result_reg <= '0;
            sign_reg   <= 1'b0;
            carry_reg  <= 1'b0;
        end else begin
            result_reg <= result_next;
            sign_reg   <= sign_next;
            carry_reg  <= carry_next;
        end
    end

    assign bus.alignedResult = result_next;
    assign bus.alignedSign   = sign_next;
    assign bus.carryOut      = carry_next;
    assign bus.aluResultQ    = result_reg;
    assign bus.aluSignQ      = sign_reg;
    assign bus.aluCarryQ     = carry_reg;
endmodule

// File: tb/tb_alu.sv
// Randomized and directed check of the mantissa ALU against a signed-arithmetic model.
module tb_alu;
    fpbus bus ();

    alu #(.MANT_W(23)) dut (
        .bus (bus)
    );

    logic clk_en;
    int   n_vec;
    int   n_miss;

    always #5 if (clk_en) bus.clk = ~bus.clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model: treat each operand as a signed integer and add them.
    function automatic void ref_model(input logic sa, input logic sb,
                                      input logic [22:0] a, input logic [22:0] b,
                                      output logic [22:0] r, output logic s, output logic c);
        int va, vb, tot;
        va = int'(a);
        vb = int'(b);
        if (sa == sb) begin
            tot = va + vb;
            r = tot[22:0];
            c = tot[23];
            s = sa;
        end else begin
            tot = (sa ? -va : va) + (sb ? -vb : vb);
            c = 1'b0;
            if (tot == 0) begin
                r = '0;
                s = 1'b0;
            end else if (tot < 0) begin
                r = 23'(-tot);
                s = 1'b1;
            end else begin
                r = 23'(tot);
                s = 1'b0;
            end
        end
    endfunction

    task automatic drive(input logic sa, input logic sb, input logic [22:0] a, input logic [22:0] b);
        bus.signA            = sa;
        bus.signB            = sb;
        bus.alignedMantissaA = a;
        bus.alignedMantissaB = b;
    endtask

    // Drive one vector, let it settle, check the combinational outputs.
    task automatic apply_comb(input string tag, input logic sa, input logic sb,
                              input logic [22:0] a, input logic [22:0] b);
        logic [22:0] er;
        logic        es, ec;
        drive(sa, sb, a, b);
        #1;
        ref_model(sa, sb, a, b, er, es, ec);
        $display("vec %s sa=%0b sb=%0b a=%06h b=%06h -> r=%06h s=%0b c=%0b",
                 tag, sa, sb, a, b, bus.alignedResult, bus.alignedSign, bus.carryOut);
        check({tag, ".result"}, 32'(bus.alignedResult), 32'(er));
        check({tag, ".sign"},   32'(bus.alignedSign),   32'(es));
        check({tag, ".carry"},  32'(bus.carryOut),      32'(ec));
    endtask

    task automatic check_q(input string tag, input logic [22:0] er, input logic es, input logic ec);
        check({tag, ".resultQ"}, 32'(bus.aluResultQ), 32'(er));
        check({tag, ".signQ"},   32'(bus.aluSignQ),   32'(es));
        check({tag, ".carryQ"},  32'(bus.aluCarryQ),  32'(ec));
    endtask

    initial begin
        logic [22:0] er, a, b;
        logic        es, ec, sa, sb;
        n_vec  = 0;
        n_miss = 0;
        clk_en = 1'b0;
        bus.clk   = 1'b0;
        bus.rst_n = 1'b1;
        drive(1'b0, 1'b0, 23'h0, 23'h0);
        #2 bus.rst_n = 1'b0;
        #2;
        check_q("reset_noclk", 23'h0, 1'b0, 1'b0);

        // Directed cases with hand-derived constants.
        apply_comb("sub_a_big", 1'b1, 1'b0, 23'h440000, 23'h240000);
        check("sub_a_big.const", 32'(bus.alignedResult), 32'h200000);
        apply_comb("sub_b_big", 1'b1, 1'b0, 23'h040000, 23'h440000);
        check("sub_b_big.sign_const", 32'(bus.alignedSign), 32'h0);
        apply_comb("sub_b_big_sw", 1'b0, 1'b1, 23'h040000, 23'h440000);
        check("sub_b_big_sw.sign_const", 32'(bus.alignedSign), 32'h1);
        apply_comb("add_pos", 1'b0, 1'b0, 23'h440000, 23'h002000);
        apply_comb("add_pos_sw", 1'b0, 1'b0, 23'h002000, 23'h440000);
        apply_comb("add_neg", 1'b1, 1'b1, 23'h440000, 23'h002000);
        check("add_neg.const", 32'(bus.alignedResult), 32'h442000);
        apply_comb("carry_neg", 1'b1, 1'b1, 23'h702000, 23'h440000);
        check("carry_neg.const", 32'(bus.alignedResult), 32'h342000);
        check("carry_neg.cconst", 32'(bus.carryOut), 32'h1);
        apply_comb("carry_pos", 1'b0, 1'b0, 23'h702000, 23'h440000);
        apply_comb("equal_mag", 1'b0, 1'b1, 23'h123456, 23'h123456);
        apply_comb("neg_zero", 1'b1, 1'b1, 23'h0, 23'h0);
        check("neg_zero.sign_const", 32'(bus.alignedSign), 32'h1);
        apply_comb("max_add", 1'b0, 1'b0, 23'h7fffff, 23'h7fffff);

        // Registered path: release reset, capture the carry case.
        clk_en = 1'b1;
        @(negedge bus.clk);
        bus.rst_n = 1'b1;
        drive(1'b1, 1'b1, 23'h702000, 23'h440000);
        @(posedge bus.clk);
        #1;
        check_q("q_carry", 23'h342000, 1'b1, 1'b1);

        // Asynchronous clear in the middle of the high phase.
        #2 bus.rst_n = 1'b0;
        #1;
        check_q("q_async_clr", 23'h0, 1'b0, 1'b0);
        @(posedge bus.clk);
        #1;
        check_q("q_held_rst", 23'h0, 1'b0, 1'b0);
        @(negedge bus.clk);
        bus.rst_n = 1'b1;

        // Randomized vectors; equal magnitudes and zeros are forced now and then.
        for (int i = 0; i < 200; i++) begin
            sa = 1'($urandom);
            sb = 1'($urandom);
            a  = 23'($urandom);
            b  = 23'($urandom);
            case ($urandom_range(0, 7))
                0: b = a;
                1: a = '0;
                2: begin a = 23'h7fffff; b = 23'($urandom_range(1, 16)); end
                default: ;
            endcase
            apply_comb($sformatf("rnd%0d", i), sa, sb, a, b);
            ref_model(sa, sb, a, b, er, es, ec);
            @(posedge bus.clk);
            #1;
            check_q($sformatf("rnd%0d", i), er, es, ec);
            @(negedge bus.clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
